axil_apb_front: RTL

- AXI4-Lite slave front end of the AXI4-Lite-to-APB bridge. Sits directly upstream of the APB master stage.
- Accepts AW/W/AR channels and buffers one write and one read.
- Arbitrates between the buffered write and read, and drives a single held-level request to the APB master stage.
- Returns that stage's completion on the B or R channel.
- One transfer in flight downstream at a time.

---
 rtl/axil_apb_front.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/axil_apb_front.sv
// rtl/axil_apb_front.sv - AXI4-Lite slave front end that buffers one write and one read
// and hands them, one at a time, to the APB master stage as a held-level request.
module axil_apb_front #(
    parameter int dataWidth = 32,
    parameter int addrWidth = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [addrWidth-1:0]   awaddr,
    input  logic [2:0]             awprot,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [dataWidth-1:0]   wdata,
    input  logic [dataWidth/8-1:0] wstrb,
    output logic                   bvalid,
    input  logic                   bready,
    output logic [1:0]             bresp,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [addrWidth-1:0]   araddr,
    input  logic [2:0]             arprot,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [dataWidth-1:0]   rdata,
    output logic [1:0]             rresp,
    output logic                   req_sel,
    output logic                   req_write,
    output logic [addrWidth-1:0]   req_addr,
    output logic [2:0]             req_prot,
    output logic [dataWidth-1:0]   req_wdata,
    output logic [dataWidth/8-1:0] req_strb,
    input  logic                   rsp_done,
    input  logic [dataWidth-1:0]   rsp_rdata,
    input  logic                   rsp_slverr
);
    localparam int StrbW = dataWidth / 8;

    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, WR_RSP, RD_RSP} state_t;

    state_t               state_q, state_d;
    logic                 aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
    logic [addrWidth-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [2:0]           aw_prot_q, aw_prot_d, ar_prot_q, ar_prot_d;
    logic [dataWidth-1:0] w_data_q, w_data_d;
    logic [StrbW-1:0]     w_strb_q, w_strb_d;
    logic                 awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                 bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]           bresp_q, bresp_d, rresp_q, rresp_d;
    logic [dataWidth-1:0] rdata_q, rdata_d;
    logic                 req_sel_q, req_sel_d, req_write_q, req_write_d;
    logic [addrWidth-1:0] req_addr_q, req_addr_d;
    logic [2:0]           req_prot_q, req_prot_d;
    logic [dataWidth-1:0] req_wdata_q, req_wdata_d;
    logic [StrbW-1:0]     req_strb_q, req_strb_d;
    logic                 last_wr_q, last_wr_d;
    logic                 wr_pend, rd_pend;

    always_comb begin
        state_d     = state_q;
        aw_full_d   = aw_full_q;
        w_full_d    = w_full_q;
        ar_full_d   = ar_full_q;
        aw_addr_d   = aw_addr_q;
        aw_prot_d   = aw_prot_q;
        ar_addr_d   = ar_addr_q;
        ar_prot_d   = ar_prot_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        bvalid_d    = bvalid_q;
        rvalid_d    = rvalid_q;
        bresp_d     = bresp_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        req_sel_d   = req_sel_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_prot_d  = req_prot_q;
        req_wdata_d = req_wdata_q;
        req_strb_d  = req_strb_q;
        last_wr_d   = last_wr_q;
        wr_pend     = aw_full_q & w_full_q;
        rd_pend     = ar_full_q;

        if (awvalid && awready_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr;
            aw_prot_d = awprot;
        end
        if (wvalid && wready_q) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
        if (arvalid && arready_q) begin
            ar_full_d = 1'b1;
            ar_addr_d = araddr;
            ar_prot_d = arprot;
        end

        // Pending status comes from registered buffer flags, so a capture waits one edge before issue
        case (state_q)
            IDLE: begin
                if (wr_pend && (!rd_pend || !last_wr_q)) begin
                    state_d     = WR_REQ;
                    req_sel_d   = 1'b1;
                    req_write_d = 1'b1;
                    req_addr_d  = aw_addr_q;
                    req_prot_d  = aw_prot_q;
                    req_wdata_d = w_data_q;
                    req_strb_d  = w_strb_q;
                end else if (rd_pend) begin
                    state_d     = RD_REQ;
                    req_sel_d   = 1'b1;
                    req_write_d = 1'b0;
                    req_addr_d  = ar_addr_q;
                    req_prot_d  = ar_prot_q;
                    req_wdata_d = '0;
                    req_strb_d  = '0;
                end
            end
            WR_REQ: begin
                if (rsp_done) begin
                    state_d   = WR_RSP;
                    req_sel_d = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = rsp_slverr ? 2'b10 : 2'b00;
                    last_wr_d = 1'b1;
                end
            end
            RD_REQ: begin
                if (rsp_done) begin
                    state_d   = RD_RSP;
                    req_sel_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rresp_d   = rsp_slverr ? 2'b10 : 2'b00;
                    rdata_d   = rsp_rdata;
                    last_wr_d = 1'b0;
                end
            end
            WR_RSP: begin
                if (bready) begin
                    state_d   = IDLE;
                    bvalid_d  = 1'b0;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                end
            end
            RD_RSP: begin
                if (rready) begin
                    state_d   = IDLE;
                    rvalid_d  = 1'b0;
                    ar_full_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        awready_d = ~aw_full_d;
        wready_d  = ~w_full_d;
        arready_d = ~ar_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            ar_full_q   <= 1'b0;
            aw_addr_q   <= '0;
            aw_prot_q   <= '0;
            ar_addr_q   <= '0;
            ar_prot_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            bresp_q     <= '0;
            rresp_q     <= '0;
            rdata_q     <= '0;
            req_sel_q   <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_prot_q  <= '0;
            req_wdata_q <= '0;
            req_strb_q  <= '0;
            last_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_full_q   <= aw_full_d;
            w_full_q    <= w_full_d;
            ar_full_q   <= ar_full_d;
            aw_addr_q   <= aw_addr_d;
            aw_prot_q   <= aw_prot_d;
            ar_addr_q   <= ar_addr_d;
            ar_prot_q   <= ar_prot_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            arready_q   <= arready_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            bresp_q     <= bresp_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            req_sel_q   <= req_sel_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_prot_q  <= req_prot_d;
            req_wdata_q <= req_wdata_d;
            req_strb_q  <= req_strb_d;
            last_wr_q   <= last_wr_d;
        end
    end

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign arready   = arready_q;
    assign bvalid    = bvalid_q;
    assign bresp     = bresp_q;
    assign rvalid    = rvalid_q;
    assign rresp     = rresp_q;
    assign rdata     = rdata_q;
    assign req_sel   = req_sel_q;
    assign req_write = req_write_q;
    assign req_addr  = req_addr_q;
    assign req_prot  = req_prot_q;
    assign req_wdata = req_wdata_q;
    assign req_strb  = req_strb_q;
endmodule
